kernel_launch_controller: RTL and testbench

Front-end scheduler of the GPU. It accepts one kernel launch at a time and splits the kernel's thread count into warps of `WARP_SIZE` threads. Each warp goes to a free SIMD core under round-robin arbitration, and the block tracks per-core busy state from completion pulses. When every warp of the kernel has retired, it signals kernel completion; it sits between the host/command interface and the SIMD core array.

---
 rtl/kernel_launch_controller_pkg.sv | 32 +++
 rtl/kernel_launch_controller_rr_arbiter.sv | 49 ++++
 rtl/kernel_launch_controller.sv | 191 +++++++++++++++++++
 tb/tb_kernel_launch_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_launch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_launch_controller_pkg
// Description : Shared constants, FSM encoding and the kernel descriptor type
//               for the kernel launch controller and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_launch_controller_pkg;

    localparam int NUM_SIMD_CORES  = 4;
    localparam int LOG2_SIMD_CORES = $clog2(NUM_SIMD_CORES);
    localparam int WARP_SIZE       = 8;
    localparam int TC_W            = 16;
    localparam int PC_W            = 32;

    // Kernel descriptor. The controller keeps the launched kernel in one of
    // these: start_pc is echoed on every dispatch, thread_count counts down
    // the threads still to be issued, warp_id is the next warp index.
    typedef struct packed {
        logic [PC_W-1:0] start_pc;
        logic [TC_W-1:0] thread_count;
        logic [TC_W-1:0] warp_id;
    } kernel_t;

    // Controller FSM encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DISPATCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN    = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/kernel_launch_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_launch_controller_rr_arbiter
// Description : Purely combinational round-robin priority rotate. Grants the
//               first requester at or after ptr, wrapping past the top.
// Ports       : req   - request vector (one bit per core)
//               ptr   - index where the search starts
//               grant - one-hot grant
//               idx   - index of the granted requester
//               valid - at least one request was present
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_launch_controller_rr_arbiter
    import kernel_launch_controller_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant  = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index (ptr + i) mod N without a divider
            if (int'(ptr) + i >= N) begin
                w_cand = IDX_W'(int'(ptr) + i - N);
            end else begin
                w_cand = IDX_W'(int'(ptr) + i);
            end
            if (!valid && req[w_cand]) begin
                valid         = 1'b1;
                idx           = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kernel_launch_controller.sv
`default_nettype none
// ============================================================================
// Module      : kernel_launch_controller
// Description : GPU front-end scheduler. Accepts one kernel launch at a time,
//               splits its threads into warps of WARP_SIZE, issues each warp
//               to a free SIMD core round-robin, tracks per-core busy state
//               from completion pulses and pulses kernel_done at the end.
// Ports       : clk, rst (async, active-high)
//               kernel_valid/kernel_ready/kernel_start_pc/kernel_thread_count
//                 - launch handshake from the host
//               core_done      - per-core warp retirement pulses
//               dispatch_*     - one-cycle warp issue to the core array
//               core_busy      - registered per-core busy vector
//               kernel_done    - one-cycle kernel completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_launch_controller
    import kernel_launch_controller_pkg::*;
#(
    parameter int NUM_SIMD_CORES = kernel_launch_controller_pkg::NUM_SIMD_CORES,
    parameter int WARP_SIZE      = kernel_launch_controller_pkg::WARP_SIZE,
    parameter int TC_W           = kernel_launch_controller_pkg::TC_W,
    parameter int PC_W           = kernel_launch_controller_pkg::PC_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              kernel_valid,
    output logic                              kernel_ready,
    input  logic [PC_W-1:0]                   kernel_start_pc,
    input  logic [TC_W-1:0]                   kernel_thread_count,
    input  logic [NUM_SIMD_CORES-1:0]         core_done,
    output logic                              dispatch_valid,
    output logic [$clog2(NUM_SIMD_CORES)-1:0] dispatch_core_id,
    output logic [PC_W-1:0]                   dispatch_pc,
    output logic [TC_W-1:0]                   dispatch_warp_id,
    output logic [$clog2(WARP_SIZE):0]        dispatch_threads,
    output logic [NUM_SIMD_CORES-1:0]         core_busy,
    output logic                              kernel_done
);

    localparam int c_CID_W = $clog2(NUM_SIMD_CORES);
    localparam int c_THR_W = $clog2(WARP_SIZE) + 1;
    localparam int c_OUT_W = $clog2(NUM_SIMD_CORES) + 1;
    localparam logic [TC_W-1:0] c_WARP_TC = TC_W'(WARP_SIZE);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    kernel_t                   r_kernel;
    logic [c_OUT_W-1:0]        r_outstanding;
    logic [NUM_SIMD_CORES-1:0] r_core_busy;
    logic [c_CID_W-1:0]        r_rr_ptr;

    logic                      r_dispatch_valid;
    logic [c_CID_W-1:0]        r_dispatch_core_id;
    logic [PC_W-1:0]           r_dispatch_pc;
    logic [TC_W-1:0]           r_dispatch_warp_id;
    logic [c_THR_W-1:0]        r_dispatch_threads;

    logic [NUM_SIMD_CORES-1:0] w_grant;
    logic [c_CID_W-1:0]        w_grant_idx;
    logic                      w_grant_valid;
    logic                      w_accept;
    logic                      w_dispatch;
    logic [c_THR_W-1:0]        w_threads;
    logic [TC_W-1:0]           w_remaining_next;
    logic [NUM_SIMD_CORES-1:0] w_done_valid;
    logic [c_OUT_W-1:0]        w_done_cnt;

    // Selection uses the registered busy vector, so a core freed this cycle
    // only becomes selectable next cycle.
    kernel_launch_controller_rr_arbiter #(
        .N     (NUM_SIMD_CORES),
        .IDX_W (c_CID_W)
    ) u_rr_arbiter (
        .req   (~r_core_busy),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_grant_idx),
        .valid (w_grant_valid)
    );

    assign w_accept   = kernel_valid && kernel_ready;
    assign w_dispatch = (r_state == c_ST_DISPATCH) && w_grant_valid;

    // Threads in the warp being issued: a full warp, or whatever is left
    always_comb begin
        if (r_kernel.thread_count >= c_WARP_TC) begin
            w_threads = c_THR_W'(WARP_SIZE);
        end else begin
            w_threads = r_kernel.thread_count[c_THR_W-1:0];
        end
    end

    // Only consumed when dispatching, where w_threads <= thread_count
    assign w_remaining_next = r_kernel.thread_count - TC_W'(w_threads);

    // Completions on idle cores are ignored
    assign w_done_valid = core_done & r_core_busy;
    assign w_done_cnt   = c_OUT_W'($countones(w_done_valid));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (kernel_thread_count == '0) ? c_ST_DONE : c_ST_DISPATCH;
                end
            end
            c_ST_DISPATCH: begin
                if (w_dispatch && (w_remaining_next == '0)) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_outstanding == '0) begin
                    w_state_next = c_ST_DONE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        kernel_ready = (r_state == c_ST_IDLE) && !rst;
        kernel_done  = (r_state == c_ST_DONE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kernel           <= '0;
            r_outstanding      <= '0;
            r_core_busy        <= '0;
            r_rr_ptr           <= '0;
            r_dispatch_valid   <= 1'b0;
            r_dispatch_core_id <= '0;
            r_dispatch_pc      <= '0;
            r_dispatch_warp_id <= '0;
            r_dispatch_threads <= '0;
        end else begin
            r_dispatch_valid <= w_dispatch;

            // Issue and retire may hit the same cycle; they net here
            r_outstanding <= r_outstanding + c_OUT_W'(w_dispatch) - w_done_cnt;
            r_core_busy   <= (r_core_busy & ~w_done_valid) | (w_dispatch ? w_grant : '0);

            if (w_accept) begin
                r_kernel.start_pc     <= kernel_start_pc;
                r_kernel.thread_count <= kernel_thread_count;
                r_kernel.warp_id      <= '0;
            end else if (w_dispatch) begin
                r_kernel.thread_count <= w_remaining_next;
                r_kernel.warp_id      <= r_kernel.warp_id + 1'b1;
            end

            if (w_dispatch) begin
                r_dispatch_core_id <= w_grant_idx;
                r_dispatch_pc      <= r_kernel.start_pc;
                r_dispatch_warp_id <= r_kernel.warp_id;
                r_dispatch_threads <= w_threads;
                if (w_grant_idx == c_CID_W'(NUM_SIMD_CORES - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_grant_idx + 1'b1;
                end
            end
        end
    end

    assign dispatch_valid   = r_dispatch_valid;
    assign dispatch_core_id = r_dispatch_core_id;
    assign dispatch_pc      = r_dispatch_pc;
    assign dispatch_warp_id = r_dispatch_warp_id;
    assign dispatch_threads = r_dispatch_threads;
    assign core_busy        = r_core_busy;

endmodule
`default_nettype wire

// File: tb/tb_kernel_launch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_launch_controller
// Description : Scoreboard bench for kernel_launch_controller. Directed
//               launches push the expected dispatches and completions (with
//               the cycle they must appear in) into queues; a monitor on the
//               falling edge pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_launch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kernel_valid = 1'b0;
    logic        kernel_ready;
    logic [31:0] kernel_start_pc = '0;
    logic [15:0] kernel_thread_count = '0;
    logic [3:0]  core_done = '0;
    logic        dispatch_valid;
    logic [1:0]  dispatch_core_id;
    logic [31:0] dispatch_pc;
    logic [15:0] dispatch_warp_id;
    logic [3:0]  dispatch_threads;
    logic [3:0]  core_busy;
    logic        kernel_done;

    kernel_launch_controller #(
        .NUM_SIMD_CORES (4),
        .WARP_SIZE      (8),
        .TC_W           (16),
        .PC_W           (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .kernel_valid        (kernel_valid),
        .kernel_ready        (kernel_ready),
        .kernel_start_pc     (kernel_start_pc),
        .kernel_thread_count (kernel_thread_count),
        .core_done           (core_done),
        .dispatch_valid      (dispatch_valid),
        .dispatch_core_id    (dispatch_core_id),
        .dispatch_pc         (dispatch_pc),
        .dispatch_warp_id    (dispatch_warp_id),
        .dispatch_threads    (dispatch_threads),
        .core_busy           (core_busy),
        .kernel_done         (kernel_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] pc;
        int          warp;
        int          thr;
    } disp_t;

    disp_t exp_q[$];
    int    done_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input bit ok, input string det);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, det);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_disp(input int c, input int core, input logic [31:0] pc,
                            input int warp, input int thr);
        disp_t e;
        e.cyc = c; e.core = core; e.pc = pc; e.warp = warp; e.thr = thr;
        exp_q.push_back(e);
    endtask

    // Drives a launch; t is the cycle in which it is accepted
    task automatic launch(input logic [31:0] pc, input int tc, output int t);
        int w;
        w = 0;
        while (!kernel_ready && w < 50) begin
            tick();
            w++;
        end
        check("launch_ready_wait", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b after %0d cycles, required 1", kernel_ready, w));
        kernel_valid        = 1'b1;
        kernel_start_pc     = pc;
        kernel_thread_count = 16'(tc);
        t = cyc;
        tick();
        kernel_valid = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m, output int x);
        core_done = m;
        x = cyc;
        tick();
        core_done = '0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        disp_t e;
        int    d;
        if (!rst) begin
            if (dispatch_valid) begin
                if (exp_q.size() == 0) begin
                    check("dispatch_unexpected", 1'b0,
                          $sformatf("got core=%0d warp=%0d at cyc %0d, required no dispatch",
                                    dispatch_core_id, dispatch_warp_id, cyc));
                end else begin
                    e = exp_q.pop_front();
                    check("dispatch",
                          cyc == e.cyc && int'(dispatch_core_id) == e.core &&
                          dispatch_pc == e.pc && int'(dispatch_warp_id) == e.warp &&
                          int'(dispatch_threads) == e.thr,
                          $sformatf("got cyc=%0d core=%0d pc=%h warp=%0d thr=%0d, required cyc=%0d core=%0d pc=%h warp=%0d thr=%0d",
                                    cyc, dispatch_core_id, dispatch_pc, dispatch_warp_id, dispatch_threads,
                                    e.cyc, e.core, e.pc, e.warp, e.thr));
                end
            end
            if (kernel_done) begin
                if (done_q.size() == 0) begin
                    check("kernel_done_unexpected", 1'b0,
                          $sformatf("got kernel_done at cyc %0d, required none", cyc));
                end else begin
                    d = done_q.pop_front();
                    check("kernel_done", cyc == d,
                          $sformatf("got kernel_done at cyc %0d, required cyc %0d", cyc, d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int t, x, y, s, a;

        // ---- Reset state ----
        tick(3);
        check("rst_ready", kernel_ready == 1'b0,
              $sformatf("kernel_ready=%0b during reset, required 0", kernel_ready));
        check("rst_dispatch",
              {dispatch_valid, dispatch_core_id, dispatch_pc, dispatch_warp_id, dispatch_threads} == '0,
              $sformatf("valid=%0b core=%0d pc=%h warp=%0d thr=%0d, required all 0",
                        dispatch_valid, dispatch_core_id, dispatch_pc, dispatch_warp_id, dispatch_threads));
        check("rst_busy_done", core_busy == 4'h0 && kernel_done == 1'b0,
              $sformatf("core_busy=%h kernel_done=%0b, required 0/0", core_busy, kernel_done));
        rst = 1'b0;
        #1;
        check("ready_after_release", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b, required 1", kernel_ready));

        // ---- Full warps: 32 threads on idle cores ----
        launch(32'h0000_1000, 32, t);
        for (int i = 0; i < 4; i++) exp_disp(t + 2 + i, i, 32'h0000_1000, i, 8);
        tick(5);
        check("full_drain_not_ready", kernel_ready == 1'b0,
              $sformatf("kernel_ready=%0b in drain, required 0", kernel_ready));
        check("full_busy", core_busy == 4'hF,
              $sformatf("core_busy=%h, required f", core_busy));
        pulse(4'hF, x);
        done_q.push_back(x + 2);
        tick();
        check("full_ready_x2", kernel_ready == 1'b0,
              $sformatf("kernel_ready=%0b at X+2, required 0", kernel_ready));
        tick();
        check("full_ready_x3", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b at X+3, required 1", kernel_ready));

        // ---- Stall for a free core: 40 threads ----
        launch(32'h0000_3000, 40, t);
        for (int i = 0; i < 4; i++) exp_disp(t + 2 + i, i, 32'h0000_3000, i, 8);
        tick(6);
        check("stall_not_ready", kernel_ready == 1'b0 && core_busy == 4'hF,
              $sformatf("kernel_ready=%0b core_busy=%h, required 0/f", kernel_ready, core_busy));
        pulse(4'b0100, x);
        exp_disp(x + 2, 2, 32'h0000_3000, 4, 8);
        tick(3);
        check("stall_busy_reissued", core_busy == 4'hF,
              $sformatf("core_busy=%h, required f", core_busy));
        pulse(4'hF, y);
        done_q.push_back(y + 2);
        tick(3);
        check("stall_ready_after", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b, required 1", kernel_ready));

        // ---- Partial last warp: 20 threads, pointer now at core 3 ----
        launch(32'h0000_2000, 20, t);
        exp_disp(t + 2, 3, 32'h0000_2000, 0, 8);
        exp_disp(t + 3, 0, 32'h0000_2000, 1, 8);
        exp_disp(t + 4, 1, 32'h0000_2000, 2, 4);
        tick(4);
        check("partial_busy", core_busy == 4'b1011,
              $sformatf("core_busy=%b, required 1011", core_busy));

        // ---- Spurious completion on idle core 2 ----
        pulse(4'b0100, s);
        tick();
        check("spurious_busy", core_busy == 4'b1011,
              $sformatf("core_busy=%b, required 1011", core_busy));
        pulse(4'b0011, a);
        tick(3);
        check("spurious_no_early_done", kernel_ready == 1'b0 && core_busy == 4'b1000,
              $sformatf("kernel_ready=%0b core_busy=%b, required 0/1000", kernel_ready, core_busy));
        pulse(4'b1000, x);
        done_q.push_back(x + 2);
        tick(3);
        check("partial_ready_after", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b, required 1", kernel_ready));

        // ---- Zero threads ----
        launch(32'h0000_4000, 0, t);
        done_q.push_back(t + 1);
        check("zero_not_ready_t1", kernel_ready == 1'b0,
              $sformatf("kernel_ready=%0b at T+1, required 0", kernel_ready));
        tick();
        check("zero_ready_t2", kernel_ready == 1'b1,
              $sformatf("kernel_ready=%0b at T+2, required 1", kernel_ready));

        // ---- Reset mid-dispatch; pointer now at core 2 ----
        launch(32'h0000_5000, 40, t);
        exp_disp(t + 2, 2, 32'h0000_5000, 0, 8);
        tick(2);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {dispatch_valid, dispatch_core_id, dispatch_pc, dispatch_warp_id,
               dispatch_threads, core_busy, kernel_done, kernel_ready} == '0,
              $sformatf("valid=%0b core=%0d pc=%h warp=%0d thr=%0d busy=%h done=%0b ready=%0b, required all 0",
                        dispatch_valid, dispatch_core_id, dispatch_pc, dispatch_warp_id,
                        dispatch_threads, core_busy, kernel_done, kernel_ready));
        tick(2);
        rst = 1'b0;
        launch(32'h0000_6000, 8, t);
        exp_disp(t + 2, 0, 32'h0000_6000, 0, 8);
        tick(3);
        pulse(4'b0001, x);
        done_q.push_back(x + 2);
        tick(4);

        // ---- Every expected event must have been seen ----
        check("dispatch_queue_empty", exp_q.size() == 0,
              $sformatf("%0d expected dispatches never seen, required 0", exp_q.size()));
        check("done_queue_empty", done_q.size() == 0,
              $sformatf("%0d expected kernel_done never seen, required 0", done_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
